int_ctrl: RTL and testbench

- Interrupt sequencer for the Gumnut core.
- Samples an external interrupt request at instruction boundaries and drives the write-enable of the interrupt save register (PC, C and Z).
- Forces the PC to the vector, tracks handler execution, and sequences the restore on reti.
- Also implements the enai, disi and stby instruction semantics.

---
 rtl/int_ctrl_pkg.sv | 32 +++
 rtl/int_sync.sv | 27 ++
 rtl/int_ctrl.sv | 123 ++++++++++++
 tb/tb_int_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/int_ctrl_pkg.sv
// Shared types and defaults for the Gumnut interrupt sequencer.
// Imported by int_ctrl and int_sync; the INT_CTRL_SYNC_EN build also uses it.
package int_ctrl_pkg;

   localparam int unsigned DEF_PC_W        = 12;
   localparam logic [11:0] DEF_VECTOR_ADDR = 12'h001;

   typedef enum logic [2:0] {
      RUN,
      STBY,
      SAVE,
      VECTOR,
      ISR,
      RESTORE
   } int_state_e;

   // Strobes that are a pure decode of the sequencer state.
   typedef struct packed {
      logic save_we;
      logic int_ack;
      logic vec_sel;
      logic restore;
      logic stall;
      logic in_isr;
   } int_ctrl_out_t;

   // disi overrides enai when both retire at the same boundary.
   function automatic logic ie_effective(input logic ie, input logic enai, input logic disi);
      return (ie | enai) & ~disi;
   endfunction

endpackage

// File: rtl/int_sync.sv
// Generic two-flop synchroniser with asynchronous active-high reset.
// Instantiated by int_ctrl only when INT_CTRL_SYNC_EN is defined.
module int_sync
   import int_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clkg,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clkg or posedge rst) begin
      if (rst) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt sequencer for the Gumnut core: save, vector, handler tracking, restore, standby.
// Define INT_CTRL_SYNC_EN to pass int_req_i through a two-flop synchroniser.
module int_ctrl
   import int_ctrl_pkg::*;
#(
   parameter int unsigned        PC_W        = DEF_PC_W,
   parameter logic [PC_W-1:0]    VECTOR_ADDR = PC_W'(DEF_VECTOR_ADDR)
) (
   input  logic            clkg,
   input  logic            rst,
   input  logic            int_req_i,
   input  logic            boundary_i,
   input  logic            enai_i,
   input  logic            disi_i,
   input  logic            reti_i,
   input  logic            stby_i,
   output logic            save_we_o,
   output logic            restore_o,
   output logic            vec_sel_o,
   output logic [PC_W-1:0] vec_addr_o,
   output logic            int_ack_o,
   output logic            stall_o,
   output logic            int_en_o,
   output logic            in_isr_o,
   output logic            reti_err_o
);

   int_state_e    state;
   int_state_e    state_nxt;
   int_ctrl_out_t outs;
   logic          req_s;
   logic          ie;
   logic          ie_eff;
   logic          reti_err;

`ifdef INT_CTRL_SYNC_EN
   int_sync #(
      .WIDTH (1)
   ) u_int_sync (
      .clkg (clkg),
      .rst  (rst),
      .d    (int_req_i),
      .q    (req_s)
   );
`else
   assign req_s = int_req_i;
`endif

   assign ie_eff = ie_effective(ie, enai_i, disi_i);

   always_ff @(posedge clkg or posedge rst) begin
      if (rst) begin
         state <= RUN;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         RUN: begin
            if (boundary_i) begin
               if (req_s && ie_eff) begin
                  state_nxt = SAVE;
               end else if (stby_i) begin
                  state_nxt = STBY;
               end
            end
         end
         // With ie clear, standby is only left through reset.
         STBY:    if (req_s && ie) state_nxt = SAVE;
         SAVE:    state_nxt = VECTOR;
         VECTOR:  state_nxt = ISR;
         ISR:     if (boundary_i && reti_i) state_nxt = RESTORE;
         RESTORE: state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   always_comb begin
      outs = '0;
      case (state)
         SAVE: begin
            outs.save_we = 1'b1;
            outs.int_ack = 1'b1;
         end
         VECTOR:  outs.vec_sel = 1'b1;
         ISR:     outs.in_isr  = 1'b1;
         RESTORE: outs.restore = 1'b1;
         STBY:    outs.stall   = 1'b1;
         default: outs = '0;
      endcase
   end

   // A reti boundary in ISR may still update ie here; RESTORE then forces it back to 1.
   always_ff @(posedge clkg or posedge rst) begin
      if (rst) begin
         ie       <= 1'b0;
         reti_err <= 1'b0;
      end else begin
         reti_err <= (state == RUN) && boundary_i && reti_i;
         case (state)
            RUN, ISR: if (boundary_i) ie <= ie_eff;
            SAVE:     ie <= 1'b0;
            RESTORE:  ie <= 1'b1;
            default:  ie <= ie;
         endcase
      end
   end

   assign save_we_o  = outs.save_we;
   assign int_ack_o  = outs.int_ack;
   assign vec_sel_o  = outs.vec_sel;
   assign restore_o  = outs.restore;
   assign stall_o    = outs.stall;
   assign in_isr_o   = outs.in_isr;
   assign vec_addr_o = VECTOR_ADDR;
   assign int_en_o   = ie;
   assign reti_err_o = reti_err;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed self-checking bench for int_ctrl; follows INT_CTRL_SYNC_EN when it is defined.
`timescale 1ns/1ps
module tb_int_ctrl;

`ifdef INT_CTRL_SYNC_EN
   localparam int SYNC_LAT = 2;
`else
   localparam int SYNC_LAT = 0;
`endif

   logic        clkg = 1'b0;
   logic        rst;
   logic        int_req_i, boundary_i, enai_i, disi_i, reti_i, stby_i;
   logic        save_we_o, restore_o, vec_sel_o, int_ack_o, stall_o;
   logic        int_en_o, in_isr_o, reti_err_o;
   logic [11:0] vec_addr_o;

   int tests = 0;
   int fails = 0;

   int_ctrl #(
      .PC_W        (12),
      .VECTOR_ADDR (12'h001)
   ) dut (
      .clkg       (clkg),
      .rst        (rst),
      .int_req_i  (int_req_i),
      .boundary_i (boundary_i),
      .enai_i     (enai_i),
      .disi_i     (disi_i),
      .reti_i     (reti_i),
      .stby_i     (stby_i),
      .save_we_o  (save_we_o),
      .restore_o  (restore_o),
      .vec_sel_o  (vec_sel_o),
      .vec_addr_o (vec_addr_o),
      .int_ack_o  (int_ack_o),
      .stall_o    (stall_o),
      .int_en_o   (int_en_o),
      .in_isr_o   (in_isr_o),
      .reti_err_o (reti_err_o)
   );

   always #5 clkg = ~clkg;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one edge; outputs are then sampled 1 ns after it.
   task automatic step();
      @(posedge clkg);
      #1;
   endtask

   task automatic boundary(input logic en, input logic di, input logic re, input logic sb);
      boundary_i = 1'b1;
      enai_i     = en;
      disi_i     = di;
      reti_i     = re;
      stby_i     = sb;
      step();
      boundary_i = 1'b0;
      enai_i     = 1'b0;
      disi_i     = 1'b0;
      reti_i     = 1'b0;
      stby_i     = 1'b0;
   endtask

   task automatic wait_sync();
      for (int i = 0; i < SYNC_LAT; i++) step();
   endtask

   initial begin
      #20000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      rst = 1'b1;
      int_req_i = 1'b0; boundary_i = 1'b0; enai_i = 1'b0;
      disi_i = 1'b0; reti_i = 1'b0; stby_i = 1'b0;
      step(); step();
      check("rst_save_we", save_we_o, 0);
      check("rst_vec_sel", vec_sel_o, 0);
      check("rst_vec_addr", vec_addr_o, 12'h001);
      check("rst_int_en", int_en_o, 0);
      check("rst_stall", stall_o, 0);
      rst = 1'b0;
      step();

      // reti outside a handler
      boundary(0, 0, 1, 0);
      check("reti_err_pulse", reti_err_o, 1);
      check("reti_err_in_isr", in_isr_o, 0);
      step();
      check("reti_err_clear", reti_err_o, 0);

      // disi beats enai at the same boundary
      int_req_i = 1'b1;
      wait_sync();
      boundary(1, 1, 0, 0);
      check("mask_no_save", save_we_o, 0);
      check("mask_int_en", int_en_o, 0);
      int_req_i = 1'b0;
      wait_sync();

      // basic entry: enai, then request at the next boundary
      boundary(1, 0, 0, 0);
      check("enai_no_save", save_we_o, 0);
      check("enai_int_en", int_en_o, 1);
      int_req_i = 1'b1;
      wait_sync();
      boundary(0, 0, 0, 0);
      check("entry_save_we", save_we_o, 1);
      check("entry_int_ack", int_ack_o, 1);
      check("entry_vec_sel_early", vec_sel_o, 0);
      step();
      check("entry_vec_sel", vec_sel_o, 1);
      check("entry_vec_addr", vec_addr_o, 12'h001);
      check("entry_save_done", save_we_o, 0);
      check("entry_ie_cleared", int_en_o, 0);
      step();
      check("entry_in_isr", in_isr_o, 1);
      check("entry_vec_sel_off", vec_sel_o, 0);
      check("entry_ack_off", int_ack_o, 0);

      // no nesting while the request stays high
      boundary(1, 0, 0, 0);
      check("nest_no_save", save_we_o, 0);
      check("nest_int_en", int_en_o, 1);
      boundary(0, 0, 0, 1);
      check("isr_stby_nop", stall_o, 0);
      check("isr_stby_in_isr", in_isr_o, 1);
      boundary(0, 1, 0, 0);
      check("isr_disi", int_en_o, 0);

      // return with request still pending
      boundary(0, 0, 1, 0);
      check("ret_restore", restore_o, 1);
      check("ret_in_isr_off", in_isr_o, 0);
      check("ret_ie_before", int_en_o, 0);
      step();
      check("ret_restore_off", restore_o, 0);
      check("ret_ie_set", int_en_o, 1);
      check("ret_no_save_yet", save_we_o, 0);
      boundary(0, 0, 0, 0);
      check("reentry_save_we", save_we_o, 1);
      step(); step();
      check("reentry_in_isr", in_isr_o, 1);
      int_req_i = 1'b0;
      boundary(0, 0, 1, 0);
      check("ret2_restore", restore_o, 1);
      step();
      check("ret2_int_en", int_en_o, 1);
      wait_sync();

      // standby with ie set, woken by a request
      boundary(0, 0, 0, 1);
      check("stby_stall", stall_o, 1);
      for (int i = 0; i < 10; i++) step();
      check("stby_still_stall", stall_o, 1);
      int_req_i = 1'b1;
      for (int i = 0; i < SYNC_LAT; i++) begin
         step();
         check("stby_wake_early", save_we_o, 0);
      end
      step();
      check("stby_wake_save", save_we_o, 1);
      check("stby_wake_stall", stall_o, 0);

      // reset in the middle of SAVE
      rst = 1'b1;
      step();
      check("rst_mid_save_we", save_we_o, 0);
      check("rst_mid_int_en", int_en_o, 0);
      check("rst_mid_in_isr", in_isr_o, 0);
      int_req_i = 1'b0;
      rst = 1'b0;
      step();
      check("rst_mid_no_vec", vec_sel_o, 0);
      check("rst_mid_no_isr", in_isr_o, 0);
      wait_sync();

      // standby with ie clear ignores the request
      boundary(0, 0, 0, 1);
      check("stby_masked_stall", stall_o, 1);
      int_req_i = 1'b1;
      for (int i = 0; i < SYNC_LAT + 3; i++) step();
      check("stby_masked_stay", stall_o, 1);
      check("stby_masked_no_save", save_we_o, 0);
      rst = 1'b1;
      step();
      check("stby_rst_exit", stall_o, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
